// File: rtl/cvxif_mac_pipe.sv
// ============================================================================
// Module   : cvxif_mac_pipe
// Brief    : Pipelined MUL/MADD/MACC/ACCRD unit with accumulator hazard
//            scoreboard, backpressure stall and kill. Optional macro
//            CVXIF_MAC_SAT_EN enables signed saturation of MACC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cvxif_mac_pipe #(
    parameter int XLEN        = 64,
    parameter int PIPE_STAGES = 2,
    parameter int NR_ACC      = 4,
    parameter int ID_WIDTH    = 3,
    localparam int AW         = (NR_ACC > 1) ? $clog2(NR_ACC) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [1:0]          issue_op_i,
    input  logic [AW-1:0]       issue_acc_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [XLEN-1:0]     issue_rs3_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic                kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [XLEN-1:0]     result_data_o,
    output logic [ID_WIDTH-1:0] result_id_o
);

    localparam logic [1:0] c_OP_MUL   = 2'b00;
    localparam logic [1:0] c_OP_MADD  = 2'b01;
    localparam logic [1:0] c_OP_MACC  = 2'b10;
    localparam logic [1:0] c_OP_ACCRD = 2'b11;

    logic [PIPE_STAGES-1:0] vld_q;
    logic [1:0]             op_q     [PIPE_STAGES];
    logic [AW-1:0]          accidx_q [PIPE_STAGES];
    logic [ID_WIDTH-1:0]    id_q     [PIPE_STAGES];
    logic [XLEN-1:0]        res_q;
    logic [XLEN-1:0]        res_d;
    logic [XLEN-1:0]        acc_q    [NR_ACC];

    logic            w_stall;
    logic            w_adv;
    logic            w_hazard;
    logic            w_fire;
    logic            w_fin_vld;
    logic [1:0]      w_fin_op;
    logic [AW-1:0]   w_fin_acc;
    logic [XLEN-1:0] w_fin_rs1;
    logic [XLEN-1:0] w_fin_rs2;
    logic [XLEN-1:0] w_fin_rs3;
    logic [XLEN-1:0] w_acc_rd;
    logic [XLEN-1:0] w_prod_lo;
    logic [XLEN-1:0] w_macc;

    assign w_stall = vld_q[PIPE_STAGES-1] && !result_ready_i;
    assign w_adv   = !w_stall;

    // Ops with op[1] set (MACC, ACCRD) own an accumulator until they leave.
    always_comb begin
        w_hazard = 1'b0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            if (vld_q[s] && op_q[s][1] && (accidx_q[s] == issue_acc_i))
                w_hazard = 1'b1;
        end
        if (!issue_op_i[1])
            w_hazard = 1'b0;
    end

    assign issue_ready_o = !rst_i && !kill_i && !w_stall && !w_hazard;
    assign w_fire        = issue_valid_i && issue_ready_o;

    // Source of the final-stage computation: issue port or the stage before last.
    generate
        if (PIPE_STAGES == 1) begin : g_direct
            assign w_fin_vld = w_fire;
            assign w_fin_op  = issue_op_i;
            assign w_fin_acc = issue_acc_i;
            assign w_fin_rs1 = issue_rs1_i;
            assign w_fin_rs2 = issue_rs2_i;
            assign w_fin_rs3 = issue_rs3_i;
        end else begin : g_opnd
            logic [XLEN-1:0] rs1_q [PIPE_STAGES-1];
            logic [XLEN-1:0] rs2_q [PIPE_STAGES-1];
            logic [XLEN-1:0] rs3_q [PIPE_STAGES-1];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int s = 0; s < PIPE_STAGES-1; s++) begin
                        rs1_q[s] <= '0;
                        rs2_q[s] <= '0;
                        rs3_q[s] <= '0;
                    end
                end else if (w_adv) begin
                    rs1_q[0] <= issue_rs1_i;
                    rs2_q[0] <= issue_rs2_i;
                    rs3_q[0] <= issue_rs3_i;
                    for (int s = 1; s < PIPE_STAGES-1; s++) begin
                        rs1_q[s] <= rs1_q[s-1];
                        rs2_q[s] <= rs2_q[s-1];
                        rs3_q[s] <= rs3_q[s-1];
                    end
                end
            end

            assign w_fin_vld = vld_q[PIPE_STAGES-2];
            assign w_fin_op  = op_q[PIPE_STAGES-2];
            assign w_fin_acc = accidx_q[PIPE_STAGES-2];
            assign w_fin_rs1 = rs1_q[PIPE_STAGES-2];
            assign w_fin_rs2 = rs2_q[PIPE_STAGES-2];
            assign w_fin_rs3 = rs3_q[PIPE_STAGES-2];
        end
    endgenerate

    assign w_acc_rd = acc_q[w_fin_acc];

`ifdef CVXIF_MAC_SAT_EN
    logic signed [2*XLEN-1:0] w_prod_full;
    logic        [2*XLEN:0]   w_sum_full;

    assign w_prod_full = $signed(w_fin_rs1) * $signed(w_fin_rs2);
    assign w_prod_lo   = w_prod_full[XLEN-1:0];
    assign w_sum_full  = {{(XLEN+1){w_acc_rd[XLEN-1]}}, w_acc_rd}
                       + {w_prod_full[2*XLEN-1], w_prod_full};

    // In range when every bit above the XLEN-bit sign agrees with it.
    always_comb begin
        if ((&w_sum_full[2*XLEN:XLEN-1]) || !(|w_sum_full[2*XLEN:XLEN-1]))
            w_macc = w_sum_full[XLEN-1:0];
        else if (w_sum_full[2*XLEN])
            w_macc = {1'b1, {(XLEN-1){1'b0}}};
        else
            w_macc = {1'b0, {(XLEN-1){1'b1}}};
    end
`else
    assign w_prod_lo = w_fin_rs1 * w_fin_rs2;
    assign w_macc    = w_acc_rd + w_prod_lo;
`endif

    always_comb begin
        res_d = w_prod_lo;
        case (w_fin_op)
            c_OP_MUL:   res_d = w_prod_lo;
            c_OP_MADD:  res_d = w_prod_lo + w_fin_rs3;
            c_OP_MACC:  res_d = w_macc;
            c_OP_ACCRD: res_d = w_acc_rd;
            default:    res_d = w_prod_lo;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            res_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                op_q[s]     <= '0;
                accidx_q[s] <= '0;
                id_q[s]     <= '0;
            end
            for (int a = 0; a < NR_ACC; a++)
                acc_q[a] <= '0;
        end else begin
            if (kill_i) begin
                vld_q <= '0;
            end else if (w_adv) begin
                vld_q[0] <= w_fire;
                for (int s = 1; s < PIPE_STAGES; s++)
                    vld_q[s] <= vld_q[s-1];
            end
            if (w_adv) begin
                op_q[0]     <= issue_op_i;
                accidx_q[0] <= issue_acc_i;
                id_q[0]     <= issue_id_i;
                for (int s = 1; s < PIPE_STAGES; s++) begin
                    op_q[s]     <= op_q[s-1];
                    accidx_q[s] <= accidx_q[s-1];
                    id_q[s]     <= id_q[s-1];
                end
                if (w_fin_vld)
                    res_q <= res_d;
            end
            // A killed op never reaches the last stage, so it must not write.
            if (w_adv && w_fin_vld && !kill_i && w_fin_op[1])
                acc_q[w_fin_acc] <= w_fin_op[0] ? '0 : w_macc;
        end
    end

    assign result_valid_o = vld_q[PIPE_STAGES-1];
    assign result_data_o  = res_q;
    assign result_id_o    = id_q[PIPE_STAGES-1];

endmodule

`default_nettype wire
